// File: rtl/song_player_if.sv
`default_nettype none
// ============================================================================
// Module      : song_player_if
// Description : Control, note-ROM and audio signals of the song player.
//               The player is the slave; the controller/ROM side is master.
// Revision    : 1.0 - initial release
// ============================================================================
interface song_player_if;
    logic       start;
    logic       stop;
    logic       pause;
    logic       loop;
    logic       song_sel;
    logic [9:0] note_in;
    logic [9:0] address;
    logic       rom_sel;
    logic [9:0] cur_note;
    logic       speaker;
    logic       playing;
    logic       done;

    modport slave (
        input  start, stop, pause, loop, song_sel, note_in,
        output address, rom_sel, cur_note, speaker, playing, done
    );

    modport master (
        output start, stop, pause, loop, song_sel, note_in,
        input  address, rom_sel, cur_note, speaker, playing, done
    );
endinterface
`default_nettype wire

// File: rtl/song_player.sv
`default_nettype none
// ============================================================================
// Module      : song_player
// Description : Steps through a note ROM one entry per TICK_CYCLES clocks and
//               renders each note as a square wave on the speaker output.
// Revision    : 1.0 - initial release
// ============================================================================
module song_player #(
    parameter int CLK_HZ      = 100_000_000,
    parameter int TICK_CYCLES = 12_500_000,
    parameter int SONG0_LEN   = 365,
    parameter int SONG1_LEN   = 261
) (
    input  wire logic     clk,
    input  wire logic     rst,
    song_player_if.slave  bus
);

    localparam int              CNT_W       = $clog2(TICK_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [9:0]      c_LAST0     = 10'(SONG0_LEN - 1);
    localparam logic [9:0]      c_LAST1     = 10'(SONG1_LEN - 1);
    localparam real             c_SEMITONE  = 1.0594630943592953;

    // Half-period table indexed by note number 0..63 (entry 0 is never used
    // because note 0 is a rest).
    typedef logic [31:0] half_tab_t [64];

    function automatic half_tab_t f_half_tab();
        half_tab_t tab;
        for (int n = 0; n < 64; n++) begin
            real        freq;
            int         semi;
            int         oct;
            logic [31:0] base;
            semi = n % 12;
            oct  = n / 12;
            freq = 440.0;
            for (int i = semi; i < 8; i++) freq = freq / c_SEMITONE;
            for (int i = 8; i < semi; i++) freq = freq * c_SEMITONE;
            base = 32'($rtoi(real'(CLK_HZ) / (2.0 * freq) + 0.5));
            tab[n] = (oct >= 3) ? (base >> (oct - 3)) : (base << (3 - oct));
        end
        return tab;
    endfunction

    localparam half_tab_t c_HALF = f_half_tab();

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [9:0]       r_addr;
    logic [9:0]       w_addr_nxt;
    logic             r_rom_sel;
    logic             w_rom_sel_nxt;
    logic [9:0]       r_cur_note;
    logic [9:0]       w_note_nxt;
    logic             w_load;
    logic [31:0]      r_div;
    logic [31:0]      w_div_nxt;
    logic             r_tone;
    logic             w_tone_nxt;
    logic             r_spk;
    logic             r_playing;
    logic             r_done;

    logic [9:0]       w_last;
    logic             w_active;
    logic             w_nxt_active;
    logic             w_audible;
    logic [31:0]      w_half;

    assign w_last       = r_rom_sel ? c_LAST1 : c_LAST0;
    assign w_active     = (r_state == S_FETCH) || (r_state == S_LOAD) || (r_state == S_PLAY);
    assign w_nxt_active = (w_state_nxt == S_FETCH) || (w_state_nxt == S_LOAD) ||
                          (w_state_nxt == S_PLAY);
    assign w_audible    = (r_cur_note != 10'd0) && (r_cur_note < 10'd64);
    assign w_half       = c_HALF[r_cur_note[5:0]];

    // Sequencer: next state, entry counter, ROM address and note latch
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_addr_nxt    = r_addr;
        w_rom_sel_nxt = r_rom_sel;
        w_note_nxt    = r_cur_note;
        w_load        = 1'b0;
        if (bus.stop) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_addr_nxt  = '0;
            w_note_nxt  = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        w_state_nxt   = S_FETCH;
                        w_cnt_nxt     = '0;
                        w_addr_nxt    = '0;
                        w_rom_sel_nxt = bus.song_sel;
                    end
                end
                S_FETCH: begin
                    if (!bus.pause) begin
                        w_state_nxt = S_LOAD;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (!bus.pause) begin
                        w_state_nxt = S_PLAY;
                        w_cnt_nxt   = r_cnt + 1'b1;
                        w_note_nxt  = bus.note_in;
                        w_load      = 1'b1;
                    end
                end
                S_PLAY: begin
                    if (!bus.pause) begin
                        if (r_cnt == c_CNT_LAST) begin
                            w_cnt_nxt = '0;
                            if (r_addr < w_last) begin
                                w_addr_nxt  = r_addr + 10'd1;
                                w_state_nxt = S_FETCH;
                            end else begin
                                w_addr_nxt  = '0;
                                w_state_nxt = bus.loop ? S_FETCH : S_DONE;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Tone divider: runs only while actively playing an audible note; a new,
    // different note restarts the phase, a repeated note keeps it
    always_comb begin
        w_div_nxt  = r_div;
        w_tone_nxt = r_tone;
        if (!w_active || !w_nxt_active) begin
            w_div_nxt  = '0;
            w_tone_nxt = 1'b0;
        end else if (bus.pause) begin
            w_div_nxt  = r_div;
            w_tone_nxt = r_tone;
        end else if (w_load && (w_note_nxt != r_cur_note)) begin
            w_div_nxt  = '0;
            w_tone_nxt = 1'b0;
        end else if (!w_audible) begin
            w_div_nxt  = '0;
            w_tone_nxt = 1'b0;
        end else if (r_div >= w_half - 32'd1) begin
            w_div_nxt  = '0;
            w_tone_nxt = ~r_tone;
        end else begin
            w_div_nxt  = r_div + 32'd1;
        end
    end

    // State and output registers; speaker is muted while paused
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_rom_sel  <= 1'b0;
            r_cur_note <= '0;
            r_div      <= '0;
            r_tone     <= 1'b0;
            r_spk      <= 1'b0;
            r_playing  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_addr     <= w_addr_nxt;
            r_rom_sel  <= w_rom_sel_nxt;
            r_cur_note <= w_note_nxt;
            r_div      <= w_div_nxt;
            r_tone     <= w_tone_nxt;
            r_spk      <= w_tone_nxt && !(w_active && bus.pause);
            r_playing  <= w_nxt_active;
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.address  = r_addr;
    assign bus.rom_sel  = r_rom_sel;
    assign bus.cur_note = r_cur_note;
    assign bus.speaker  = r_spk;
    assign bus.playing  = r_playing;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_song_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_song_player
// Description : Self-checking bench for song_player against a position-in-song
//               reference model with directed and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_song_player;

    localparam int CLK_HZ = 20_000;
    localparam int TICK   = 32;
    localparam int L0     = 4;
    localparam int L1     = 3;

    logic clk = 1'b0;
    logic rst;

    song_player_if bus ();

    song_player #(
        .CLK_HZ      (CLK_HZ),
        .TICK_CYCLES (TICK),
        .SONG0_LEN   (L0),
        .SONG1_LEN   (L1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Note ROM with a one-cycle registered read
    logic [9:0] rom [2][16];
    always @(posedge clk) bus.note_in <= rom[bus.rom_sel][bus.address[3:0]];

    int n_vec = 0;
    int n_err = 0;
    int cyc_n = 0;

    // Reference model state: song position plus time since the note began
    int m_act, m_done, m_addr, m_song, m_note, m_phase, m_t, m_spk;

    function automatic int half_of(int n);
        int   s;
        int   k;
        int   t;
        real  f;
        s = n % 12;
        k = n / 12;
        f = 440.0 * (2.0 ** ((real'(s) - 8.0) / 12.0));
        t = $rtoi(real'(CLK_HZ) / (2.0 * f) + 0.5);
        return (k >= 3) ? (t >> (k - 3)) : (t << (3 - k));
    endfunction

    function automatic bit audible(int n);
        return (n != 0) && (n < 64);
    endfunction

    function automatic int len_of(int song);
        return (song != 0) ? L1 : L0;
    endfunction

    always @(posedge clk) begin : model
        bit paused_edge;
        int nn;
        paused_edge = 1'b0;
        cyc_n++;
        if (rst) begin
            m_act = 0; m_done = 0; m_addr = 0; m_song = 0;
            m_note = 0; m_phase = 0; m_t = 0;
        end else if (bus.stop) begin
            m_act = 0; m_done = 0; m_addr = 0; m_note = 0; m_phase = 0; m_t = 0;
        end else if (m_act == 0) begin
            if (bus.start) begin
                m_act = 1; m_done = 0; m_song = int'(bus.song_sel);
                m_addr = 0; m_phase = 0; m_t = 0;
            end
        end else if (bus.pause) begin
            paused_edge = 1'b1;
        end else begin
            m_t++;
            if (m_phase == 1) begin
                nn = int'(rom[m_song][m_addr]);
                if (nn != m_note) m_t = 0;
                m_note = nn;
            end
            if (m_phase == TICK - 1) begin
                m_phase = 0;
                if (m_addr < len_of(m_song) - 1) begin
                    m_addr++;
                end else begin
                    m_addr = 0;
                    if (!bus.loop) begin
                        m_act  = 0;
                        m_done = 1;
                    end
                end
            end else begin
                m_phase++;
            end
            if (!audible(m_note)) m_t = 0;
        end
        if (m_act == 0) m_t = 0;
        m_spk = (m_act != 0 && !paused_edge && audible(m_note) &&
                 ((m_t / half_of(m_note)) % 2 == 1)) ? 1 : 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        chk("address",  32'(bus.address),  32'(m_addr));
        chk("rom_sel",  32'(bus.rom_sel),  32'(m_song));
        chk("cur_note", 32'(bus.cur_note), 32'(m_note));
        chk("speaker",  32'(bus.speaker),  32'(m_spk));
        chk("playing",  32'(bus.playing),  32'(m_act));
        chk("done",     32'(bus.done),     32'(m_done));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic pulse_start(input logic sel);
        bus.song_sel = sel;
        bus.start    = 1'b1;
        cyc();
        bus.start    = 1'b0;
    endtask

    function automatic logic [9:0] rand_note();
        case ($urandom_range(0, 5))
            0:       return 10'd0;
            1:       return 10'd44;
            2:       return 10'd32;
            3:       return 10'd56;
            4:       return 10'($urandom_range(1, 63));
            default: return 10'($urandom_range(64, 1023));
        endcase
    endfunction

    initial begin
        for (int s = 0; s < 2; s++)
            for (int a = 0; a < 16; a++) rom[s][a] = 10'd0;
        rst = 1'b1;
        bus.start = 1'b1; bus.stop = 1'b1; bus.pause = 1'b0;
        bus.loop = 1'b0; bus.song_sel = 1'b1;

        // Reset with start/stop also asserted: reset wins
        run(2);
        bus.start = 1'b0; bus.stop = 1'b0; bus.song_sel = 1'b0;
        rst = 1'b0;
        run(2);

        // Plain playback of song 0 through to DONE
        rom[0][0] = 10'd44; rom[0][1] = 10'd44; rom[0][2] = 10'd0; rom[0][3] = 10'd32;
        pulse_start(1'b0);
        run(4 * TICK + 6);

        // Restart from DONE; a start during playback is ignored
        rom[0][0] = 10'd56; rom[0][1] = 10'd44; rom[0][2] = 10'd44; rom[0][3] = 10'd56;
        pulse_start(1'b0);
        run(TICK + 5);
        pulse_start(1'b1);
        run(3 * TICK);

        // Looping song 1
        rom[1][0] = 10'd32; rom[1][1] = 10'd70; rom[1][2] = 10'd44;
        bus.loop = 1'b1;
        pulse_start(1'b1);
        run(7 * L1 * TICK / 3 + 10);
        bus.loop = 1'b0;

        // Pause for 20 clocks in the middle of an entry
        bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
        pulse_start(1'b0);
        run(TICK + 12);
        bus.pause = 1'b1;
        run(20);
        bus.pause = 1'b0;
        run(3 * TICK + 10);

        // Start and stop together during PLAY, then a lone start
        pulse_start(1'b1);
        run(TICK + 10);
        bus.start = 1'b1; bus.stop = 1'b1;
        cyc();
        bus.start = 1'b0; bus.stop = 1'b0;
        run(3);
        pulse_start(1'b1);
        run(TICK + 4);

        // Reset for one clock mid-play, then normal playback
        rst = 1'b1; cyc(); rst = 1'b0;
        run(2);
        pulse_start(1'b0);
        run(4 * TICK + 4);

        // Randomized sessions
        for (int it = 0; it < 8; it++) begin
            bus.stop = 1'b1; cyc(); bus.stop = 1'b0;
            for (int s = 0; s < 2; s++)
                for (int a = 0; a < 4; a++) rom[s][a] = rand_note();
            bus.loop = 1'($urandom_range(0, 1));
            for (int c = 0; c < 400; c++) begin
                bus.start    = ($urandom_range(0, 39) == 0);
                bus.stop     = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 24) == 0) bus.pause = ~bus.pause;
                if ($urandom_range(0, 99) == 0) bus.loop = ~bus.loop;
                bus.song_sel = 1'($urandom_range(0, 1));
                cyc();
            end
            bus.start = 1'b0; bus.stop = 1'b0; bus.pause = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/song_player.md
SONG_PLAYER -- requirements
Module: song_player

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, the system clock frequency used to derive tone periods.
REQ-002 SHALL have parameter TICK_CYCLES, default 12_500_000, the clocks per ROM entry (one sixteenth note); legal values are 4 or more.
REQ-003 SHALL have parameters SONG0_LEN, default 365, and SONG1_LEN, default 261, the number of entries in each song.
REQ-004 SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
REQ-005 SHALL have the following control and data ports:
- start  in  1  pulse; begin playback from entry 0
- stop  in  1  pulse; abort playback, go to IDLE
- pause  in  1  level; freeze playback and mute
- loop  in  1  level; restart at entry 0 when the song ends
- song_sel  in  1  song to play (0 or 1); sampled only on start
- note_in  in  10  note number returned by the selected note ROM
- address  out  10  note ROM address
- rom_sel  out  1  latched song_sel; drives the ROM output mux
- cur_note  out  10  note currently sounding
- speaker  out  1  square-wave audio output
- playing  out  1  high in FETCH, LOAD and PLAY
- done  out  1  high in DONE

Function
REQ-006 SHALL implement the states IDLE, FETCH, LOAD, PLAY and DONE.
REQ-007 SHALL treat the note ROM as a 1-cycle registered read: note_in reflects the address of the previous clock.
REQ-008 In IDLE, start SHALL do all of the following on one edge: latch rom_sel <= song_sel, set address <= 0, clear the entry counter, and go to FETCH.
REQ-009 FETCH SHALL last 1 cycle; LOAD SHALL last 1 cycle and latch cur_note <= note_in on its final edge.
REQ-010 The entry counter SHALL count every unpaused cycle from FETCH entry; PLAY ends when the counter equals TICK_CYCLES-1, so each entry lasts exactly TICK_CYCLES unpaused clocks.
REQ-011 At the end of PLAY, if address < len-1 (len = SONG0_LEN or SONG1_LEN per rom_sel), the block SHALL set address <= address+1 and go to FETCH.
REQ-012 At the end of PLAY on the last entry, the block SHALL go to FETCH with address <= 0 if loop=1; otherwise it SHALL go to DONE with address <= 0.
REQ-013 While pause=1 in FETCH, LOAD or PLAY, the block SHALL hold the state, the counter, address and the tone divider, and SHALL force speaker=0; on release it SHALL resume with no lost or extra cycles.
REQ-014 stop SHALL force IDLE from any state, with address=0, cur_note=0 and speaker=0.
REQ-015 If stop and start are asserted together, stop SHALL win.
REQ-016 start SHALL be ignored outside IDLE and DONE; in DONE it SHALL behave exactly as in IDLE.
REQ-017 Tone: for cur_note n, with s = n mod 12 and k = n / 12, the half-period H SHALL be:
- H = T[s] >> (k-3) when k >= 3
- H = T[s] << (3-k) when k < 3
- T[s] = round(CLK_HZ / (2 * 440 * 2^((s-8)/12))); s=0 is C#/Db, s=8 is A (note 44 = A4 = 440 Hz).
REQ-018 The tone divider SHALL be at least 24 bits and SHALL toggle speaker each time it reaches H-1, then restart from 0.
REQ-019 cur_note = 0 SHALL be a rest: speaker=0 and the divider held at 0.
REQ-020 cur_note >= 64 SHALL be treated as a rest.
REQ-021 When a newly latched cur_note equals the previous one, the divider phase SHALL continue uninterrupted.
REQ-022 When a newly latched cur_note differs from the previous one, the divider SHALL restart from 0 and speaker SHALL go to 0.
REQ-023 In IDLE and DONE, speaker SHALL be 0.
REQ-024 All outputs SHALL be registered.

Reset
REQ-025 rst SHALL force state=IDLE, with address=0, rom_sel=0, cur_note=0, speaker=0, playing=0, done=0, and the entry counter and divider at 0.
REQ-026 rst SHALL take priority over start and stop, and mid-playback reset SHALL be silent in the following cycle.

Verification
REQ-027 Playback: TICK_CYCLES=8, SONG0_LEN=4, ROM returning 44,44,0,32, start -> address 0,1,2,3 each held 8 clocks; cur_note latched 2 clocks after each address change; done=1 exactly 32 clocks after start.
REQ-028 Tone: CLK_HZ=100e6 with cur_note = 44, 32 and 56 -> speaker half-periods of 113636, 227272 and 56818 clocks respectively; a repeated note 44 across an entry boundary produces no phase glitch.
REQ-029 Loop: loop=1, SONG1_LEN=3, song_sel=1 -> rom_sel=1 and address sequence 0,1,2,0,1,...; done stays 0 and playing stays 1.
REQ-030 Pause: pause asserted for 20 clocks mid-entry -> speaker=0 and address frozen; the entry completes exactly 20 clocks later than unpaused.
REQ-031 Stop/start collision: start and stop in the same cycle during PLAY -> IDLE, address=0, speaker=0; a later start alone restarts at address 0.
REQ-032 Reset mid-PLAY: rst for 1 clock -> all outputs 0 on the next cycle; start then plays normally.
